// File: rtl/gate_tester_pkg.sv
// Shared definitions for the quad 2-input gate tester:
// FSM state encoding, logic-function codes, the fixed 8-entry test-vector ROM
// and the reference model of each gate function.
package gate_tester_pkg;

  localparam int unsigned GATE_W  = 4;  // gates per device
  localparam int unsigned NUM_VEC = 8;  // vectors per run
  localparam int unsigned VEC_W   = 3;  // vector index width
  localparam int unsigned FUNC_W  = 2;  // function select width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam logic [FUNC_W-1:0] FUNC_AND  = 2'b00;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 2'b01;
  localparam logic [FUNC_W-1:0] FUNC_NAND = 2'b10;
  localparam logic [FUNC_W-1:0] FUNC_XOR  = 2'b11;

  // A-side vector: truth table for k<4, walking one for k>=4
  function automatic logic [GATE_W-1:0] vec_a(input logic [VEC_W-1:0] k);
    if (k[2]) vec_a = GATE_W'(1) << k[1:0];
    else      vec_a = {GATE_W{k[1]}};
  endfunction

  // B-side vector: truth table for k<4, all zero during the walking one
  function automatic logic [GATE_W-1:0] vec_b(input logic [VEC_W-1:0] k);
    if (k[2]) vec_b = '0;
    else      vec_b = {GATE_W{k[0]}};
  endfunction

  // Expected gate outputs for the selected function
  function automatic logic [GATE_W-1:0] exp_y(input logic [FUNC_W-1:0] func,
                                               input logic [GATE_W-1:0] a,
                                               input logic [GATE_W-1:0] b);
    case (func)
      FUNC_AND:  exp_y = a & b;
      FUNC_OR:   exp_y = a | b;
      FUNC_NAND: exp_y = ~(a & b);
      default:   exp_y = a ^ b;
    endcase
  endfunction

endpackage

// File: rtl/gate_tester_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous DUT outputs.
// Ports: i_clk, i_rst_n (sync, active low), i_d (async in), o_q (synchronized out).
module sync2 #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gate_tester_ctrl.sv
// Sequencer that drives an external quad 2-input gate through 8 test vectors,
// samples its synchronized outputs and reports per-gate pass/fail.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_start, i_abort    run control (levels)
//   i_func_sel          expected function, latched on accepted start
//   i_dut_y             device outputs (asynchronous)
//   o_dut_a, o_dut_b    device inputs (registered)
//   o_busy, o_done      run in progress / one-cycle completion pulse
//   o_pass, o_fail_mask, o_fail_vec   result of the last run
module gate_tester_ctrl
  import gate_tester_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [FUNC_W-1:0] i_func_sel,
  input  logic [GATE_W-1:0] i_dut_y,
  output logic [GATE_W-1:0] o_dut_a,
  output logic [GATE_W-1:0] o_dut_b,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [GATE_W-1:0] o_fail_mask,
  output logic [VEC_W-1:0]  o_fail_vec
);

  state_e              r_state, w_state_nxt;
  logic [VEC_W-1:0]    r_k, w_k;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [FUNC_W-1:0]   r_func, w_func;
  logic [GATE_W-1:0]   r_dut_a, w_dut_a;
  logic [GATE_W-1:0]   r_dut_b, w_dut_b;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_pass, w_pass;
  logic [GATE_W-1:0]   r_fail_mask, w_fail_mask;
  logic [VEC_W-1:0]    r_fail_vec, w_fail_vec;
  logic [GATE_W-1:0]   w_y_sync;
  logic [GATE_W-1:0]   w_mism;
  logic                w_abort_busy;

  sync2 #(.W(GATE_W)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_dut_y),
    .o_q     (w_y_sync)
  );

  assign w_abort_busy = i_abort && (r_state != ST_IDLE);
  assign w_mism       = w_y_sync ^ exp_y(r_func, r_dut_a, r_dut_b);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides every busy transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start && !i_abort) w_state_nxt = ST_DRIVE;
      ST_DRIVE:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_cnt == CNT_W'(SETTLE_CYC - 1)) w_state_nxt = ST_CHECK;
      ST_CHECK:  w_state_nxt = (r_k == VEC_W'(NUM_VEC - 1)) ? ST_FINISH : ST_DRIVE;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_abort_busy) w_state_nxt = ST_IDLE;
  end

  // Next values of the datapath and output registers
  always_comb begin
    w_k         = r_k;
    w_cnt       = r_cnt;
    w_func      = r_func;
    w_dut_a     = r_dut_a;
    w_dut_b     = r_dut_b;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_pass      = r_pass;
    w_fail_mask = r_fail_mask;
    w_fail_vec  = r_fail_vec;
    if (w_abort_busy) begin
      // partial fail mask/vector are kept for inspection
      w_dut_a = '0;
      w_dut_b = '0;
      w_busy  = 1'b0;
      w_pass  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            w_k         = '0;
            w_fail_mask = '0;
            w_fail_vec  = '0;
            w_pass      = 1'b0;
            w_func      = i_func_sel;
            w_busy      = 1'b1;
          end
        end
        ST_DRIVE: begin
          w_dut_a = vec_a(r_k);
          w_dut_b = vec_b(r_k);
          w_cnt   = '0;
        end
        ST_SETTLE: w_cnt = r_cnt + CNT_W'(1);
        ST_CHECK: begin
          w_fail_mask = r_fail_mask | w_mism;
          // an empty mask means no earlier vector failed in this run
          if ((w_mism != '0) && (r_fail_mask == '0)) w_fail_vec = r_k;
          if (r_k != VEC_W'(NUM_VEC - 1)) w_k = r_k + VEC_W'(1);
        end
        ST_FINISH: begin
          w_done  = 1'b1;
          w_pass  = (r_fail_mask == '0);
          w_dut_a = '0;
          w_dut_b = '0;
          w_busy  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_k         <= '0;
      r_cnt       <= '0;
      r_func      <= '0;
      r_dut_a     <= '0;
      r_dut_b     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_mask <= '0;
      r_fail_vec  <= '0;
    end else begin
      r_k         <= w_k;
      r_cnt       <= w_cnt;
      r_func      <= w_func;
      r_dut_a     <= w_dut_a;
      r_dut_b     <= w_dut_b;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_pass      <= w_pass;
      r_fail_mask <= w_fail_mask;
      r_fail_vec  <= w_fail_vec;
    end
  end

  assign o_dut_a     = r_dut_a;
  assign o_dut_b     = r_dut_b;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_fail_mask = r_fail_mask;
  assign o_fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_gate_tester_ctrl.sv
// Directed bench for gate_tester_ctrl with a behavioural OR-gate device model
// that can inject a stuck-at-0 output, swapped input pins or a forced-high output.
module tb_gate_tester_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [1:0] func_sel;
  logic [3:0] dut_y;
  logic [3:0] dut_a;
  logic [3:0] dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [2:0] fail_vec;

  logic       mdl_stuck2;
  logic       mdl_swap;
  logic       mdl_force_f;
  logic [3:0] mdl_a;

  int n_checks = 0;
  int n_fail   = 0;

  gate_tester_ctrl u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_func_sel  (func_sel),
    .i_dut_y     (dut_y),
    .o_dut_a     (dut_a),
    .o_dut_b     (dut_b),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_fail_mask (fail_mask),
    .o_fail_vec  (fail_vec)
  );

  always #5 clk = ~clk;

  // External device model: OR gates with optional faults
  always_comb begin
    mdl_a = mdl_swap ? {dut_a[3:2], dut_a[0], dut_a[1]} : dut_a;
    dut_y = mdl_a | dut_b;
    if (mdl_stuck2)  dut_y[2] = 1'b0;
    if (mdl_force_f) dut_y = 4'hF;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept a run; returns #1 after the accepting edge with func_sel scrambled
  task automatic start_run(input logic [1:0] f);
    @(negedge clk);
    func_sel = f;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    func_sel = ~f;
  endtask

  // Count edges to DONE (bounded); optional start re-pulse at a given cycle
  task automatic wait_done(input int repulse_at, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      start = (n == repulse_at);
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_a"},    32'(dut_a), 32'h0);
    check_eq({tag, "_b"},    32'(dut_b), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_done"}, 32'(done), 32'h0);
    check_eq({tag, "_pass"}, 32'(pass), 32'h0);
    check_eq({tag, "_mask"}, 32'(fail_mask), 32'h0);
    check_eq({tag, "_vec"},  32'(fail_vec), 32'h0);
  endtask

  task automatic full_run(input string tag, input logic [1:0] f, input logic pass_e,
                          input logic [3:0] mask_e, input logic [2:0] vec_e);
    int lat;
    start_run(f);
    check_eq({tag, "_busy"}, 32'(busy), 32'h1);
    wait_done(0, lat);
    check_eq({tag, "_lat"},  32'(lat), 32'd49);
    check_eq({tag, "_pass"}, 32'(pass), 32'(pass_e));
    check_eq({tag, "_mask"}, 32'(fail_mask), 32'(mask_e));
    check_eq({tag, "_vec"},  32'(fail_vec), 32'(vec_e));
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, 32'(done), 32'h0);
    check_eq({tag, "_idle"},  32'(busy), 32'h0);
  endtask

  initial begin
    int lat;
    int cnt;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    func_sel    = 2'b00;
    mdl_stuck2  = 1'b0;
    mdl_swap    = 1'b0;
    mdl_force_f = 1'b1;

    // Reset with device outputs high
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("rst");
    rst_n = 1'b1;
    count_done(100, cnt);
    check_eq("rst_nodone", 32'(cnt), 32'd0);
    mdl_force_f = 1'b0;

    // Good OR device, expecting OR
    full_run("or_good", 2'b01, 1'b1, 4'b0000, 3'd0);

    // Y[2] stuck at 0
    mdl_stuck2 = 1'b1;
    full_run("or_stuck2", 2'b01, 1'b0, 4'b0100, 3'd1);
    mdl_stuck2 = 1'b0;

    // Good OR device checked against AND
    full_run("and_vs_or", 2'b00, 1'b0, 4'b1111, 3'd1);

    // A[0]/A[1] swapped: only the walking-one vectors catch it
    mdl_swap = 1'b1;
    full_run("or_swap", 2'b01, 1'b0, 4'b0011, 3'd4);
    mdl_swap = 1'b0;

    // Start re-pulse while busy is ignored
    start_run(2'b01);
    wait_done(10, lat);
    check_eq("repulse_lat", 32'(lat), 32'd49);
    check_eq("repulse_pass", 32'(pass), 32'h1);
    count_done(60, cnt);
    check_eq("repulse_once", 32'(cnt), 32'd0);

    // Abort in SETTLE of vector 3, with a stuck gate to leave partial results
    mdl_stuck2 = 1'b1;
    start_run(2'b01);
    repeat (20) @(posedge clk);
    #1;
    check_eq("abort_pre_busy", 32'(busy), 32'h1);
    check_eq("abort_pre_a", 32'(dut_a), 32'hF);
    check_eq("abort_pre_b", 32'(dut_b), 32'hF);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'h0);
    check_eq("abort_a", 32'(dut_a), 32'h0);
    check_eq("abort_b", 32'(dut_b), 32'h0);
    check_eq("abort_pass", 32'(pass), 32'h0);
    check_eq("abort_mask", 32'(fail_mask), 32'h4);
    check_eq("abort_vec", 32'(fail_vec), 32'h1);
    count_done(60, cnt);
    check_eq("abort_nodone", 32'(cnt), 32'd0);
    mdl_stuck2 = 1'b0;

    // Abort and start together in IDLE: stay idle
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    check_eq("abort_start_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    check_eq("abort_start_a", 32'(dut_a), 32'h0);

    // Reset in the middle of a run
    start_run(2'b01);
    repeat (20) @(posedge clk);
    #1;
    rst_n       = 1'b0;
    mdl_force_f = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("midrst");
    rst_n = 1'b1;
    count_done(100, cnt);
    check_eq("midrst_nodone", 32'(cnt), 32'd0);
    mdl_force_f = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
